mem_port_arbiter: RTL and testbench

Sequential arbiter sharing one single-ported unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage. Accepts level-held requests from both ports, grants one at a time with data priority plus a starvation guard for fetch, sequences the fixed-latency memory access, and returns a one-cycle ready pulse with registered read data. Drives per-port stall outputs consumed by the pipeline hazard logic.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between the fetch (IF)
// and data (MEM) pipeline stages: data priority with a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] WAIT_INIT  = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          grant_if;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        grant_if   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    grant_if = if_req && (!dm_req || (starve_q == STARVE_LIM));
                    state_d  = ST_ISSUE;
                    if (grant_if) begin
                        owner_d  = OWN_IF;
                        addr_d   = {if_addr[31:2], 2'b00};
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_DM;
                        addr_d  = {dm_addr[31:2], 2'b00};
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                        // Only data grants that bypass a waiting fetch count toward starvation.
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = WAIT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ready  = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign dm_ready  = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: randomized port traffic against a
// transaction-level model, plus a MEM_LAT=1 instance checked with a directed fetch.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 2;
    localparam int unsigned SM  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem;

    logic        l_if_req, l_dm_req, l_dm_we;
    logic [31:0] l_if_addr, l_dm_addr, l_dm_wdata, l_mem_rdata;
    logic [31:0] l_if_rdata, l_dm_rdata, l_mem_addr, l_mem_wdata;
    logic        l_if_ready, l_dm_ready, l_mem_en, l_mem_we, l_stall_if, l_stall_mem;
    logic        l_en_last = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SM)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(l_if_req), .if_addr(l_if_addr), .if_rdata(l_if_rdata), .if_ready(l_if_ready),
        .dm_req(l_dm_req), .dm_we(l_dm_we), .dm_addr(l_dm_addr), .dm_wdata(l_dm_wdata),
        .dm_rdata(l_dm_rdata), .dm_ready(l_dm_ready),
        .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
        .mem_rdata(l_mem_rdata), .stall_if(l_stall_if), .stall_mem(l_stall_mem)
    );

    typedef struct {
        bit          we;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    exp_t if_q[$];
    exp_t dm_q[$];
    rsp_t rq[$];
    logic [31:0] ref_mem [bit [31:0]];
    logic [31:0] phys    [bit [31:0]];

    function automatic logic [31:0] seed_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : seed_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // ---------------- memory responder (environment) ----------------
    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mem_rdata = rq[0].data;
                void'(rq.pop_front());
            end else begin
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        l_mem_rdata = '0;
        forever begin
            @(negedge clk);
            l_en_last = l_mem_en;
            @(posedge clk);
            #1;
            l_mem_rdata = l_en_last ? 32'h1357_9BDF : $urandom;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit          rst_prev = 1'b0;
        bit          grant_next = 1'b0;
        int          busy_until = -1;
        int          starve = 0;
        bit          pend_valid = 1'b0;
        bit          pend_dm = 1'b0;
        int          pend_due = 0;
        logic [31:0] last_if = '0;
        logic [31:0] last_dm = '0;
        logic        p_if_req = 1'b0, p_dm_req = 1'b0, p_dm_we = 1'b0;
        logic [31:0] p_if_addr = '0, p_dm_addr = '0, p_dm_wdata = '0;
        bit          win_dm, exp_ifr, exp_dmr;
        logic [31:0] exp_addr;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                if (mem_we === 1'b1) phys[mem_addr] = mem_wdata;
                else rq.push_back('{cyc + LAT, phys_rd(mem_addr)});
            end
            if (reset) begin
                if (rst_prev) begin
                    chk1("rst_mem_en", mem_en, 1'b0);
                    chk1("rst_mem_we", mem_we, 1'b0);
                    chk("rst_mem_addr", mem_addr, 32'h0);
                    chk("rst_mem_wdata", mem_wdata, 32'h0);
                    chk1("rst_if_ready", if_ready, 1'b0);
                    chk1("rst_dm_ready", dm_ready, 1'b0);
                    chk("rst_if_rdata", if_rdata, 32'h0);
                    chk("rst_dm_rdata", dm_rdata, 32'h0);
                    chk1("rst_stall_if", stall_if, if_req);
                    chk1("rst_stall_mem", stall_mem, dm_req);
                end
                if_q.delete();
                dm_q.delete();
                rq.delete();
                busy_until = -1;
                starve     = 0;
                pend_valid = 1'b0;
                last_if    = '0;
                last_dm    = '0;
                grant_next = 1'b0;
            end else begin
                chk1("mem_en", mem_en, grant_next);
                if (grant_next) begin
                    win_dm   = p_dm_req && !(starve == SM && p_if_req);
                    exp_addr = (win_dm ? p_dm_addr : p_if_addr) & 32'hFFFF_FFFC;
                    chk("grant_addr", mem_addr, exp_addr);
                    chk1("grant_we", mem_we, win_dm ? p_dm_we : 1'b0);
                    if (win_dm && p_dm_we) chk("grant_wdata", mem_wdata, p_dm_wdata);
                    if (!win_dm || !p_if_req) starve = 0;
                    else if (starve < SM) starve++;
                    pend_valid = 1'b1;
                    pend_dm    = win_dm;
                    pend_due   = cyc + LAT + 1;
                    busy_until = pend_due;
                end else begin
                    chk1("mem_we_idle", mem_we, 1'b0);
                end
                exp_ifr = pend_valid && pend_due == cyc && !pend_dm;
                exp_dmr = pend_valid && pend_due == cyc && pend_dm;
                chk1("if_ready", if_ready, exp_ifr);
                chk1("dm_ready", dm_ready, exp_dmr);
                if (pend_valid && pend_due == cyc) begin
                    pend_valid = 1'b0;
                    if (!pend_dm) begin
                        if (if_q.size() == 0) chk1("if_q_empty", 1'b1, 1'b0);
                        else begin e = if_q.pop_front(); last_if = e.data; end
                    end else begin
                        if (dm_q.size() == 0) chk1("dm_q_empty", 1'b1, 1'b0);
                        else begin e = dm_q.pop_front(); if (!e.we) last_dm = e.data; end
                    end
                end
                chk("if_rdata", if_rdata, last_if);
                chk("dm_rdata", dm_rdata, last_dm);
                chk1("stall_if", stall_if, if_req & ~exp_ifr);
                chk1("stall_mem", stall_mem, dm_req & ~exp_dmr);
                grant_next = (cyc > busy_until) && (if_req || dm_req);
            end
            p_if_req   = if_req;
            p_if_addr  = if_addr;
            p_dm_req   = dm_req;
            p_dm_we    = dm_we;
            p_dm_addr  = dm_addr;
            p_dm_wdata = dm_wdata;
            rst_prev   = reset;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input bit is_dm);
        bit got = 1'b0;
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            got = is_dm ? dm_ready : if_ready;
        end
        chk1(is_dm ? "dm_ready_timeout" : "if_ready_timeout", got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_if(input logic [31:0] addr);
        exp_t e;
        e.we   = 1'b0;
        e.data = seed_word(addr & 32'hFFFF_FFFC);
        if_q.push_back(e);
        if_addr = addr;
        if_req  = 1'b1;
        wait_ready(1'b0);
    endtask

    task automatic do_dm(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] a;
        a    = addr & 32'hFFFF_FFFC;
        e.we = we;
        if (we) begin
            ref_mem[a] = wd;
            e.data     = '0;
        end else begin
            e.data = ref_rd(a);
        end
        dm_q.push_back(e);
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wd;
        dm_req   = 1'b1;
        wait_ready(1'b1);
    endtask

    task automatic rand_port(input bit is_dm, input int n, input int gapmax);
        int g;
        for (int t = 0; t < n; t++) begin
            g = $urandom_range(gapmax, 0);
            if (g > 0) begin
                if (is_dm) dm_req = 1'b0;
                else if_req = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
            if (is_dm)
                do_dm(($urandom & 1) == 1,
                      32'h0001_0000 + ($urandom_range(7, 0) << 2) + $urandom_range(3, 0),
                      $urandom);
            else
                do_if(32'h2000_0000 | ($urandom & 32'h0000_0FFF));
        end
        if (is_dm) dm_req = 1'b0;
        else if_req = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog cycle=%0d simulation did not complete", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        l_if_req = 1'b0; l_if_addr = '0;
        l_dm_req = 1'b0; l_dm_we = 1'b0; l_dm_addr = '0; l_dm_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single fetch, then data write / read-back through the aligned address
        do_if(32'h0000_0040);
        if_req = 1'b0;
        do_dm(1'b1, 32'h0000_0203, 32'hDEAD_BEEF);
        dm_req = 1'b0;
        do_dm(1'b0, 32'h0000_0200, 32'h0);
        dm_req = 1'b0;
        @(posedge clk);
        #1;

        // simultaneous requests: data first, fetch next
        fork
            begin do_if(32'h0000_0080); if_req = 1'b0; end
            begin do_dm(1'b0, 32'h0000_0100, 32'h0); dm_req = 1'b0; end
        join

        // both ports saturated: starvation guard must interleave fetches
        fork
            rand_port(1'b0, 4, 0);
            rand_port(1'b1, 14, 0);
        join

        // randomized mixed traffic
        fork
            rand_port(1'b0, 40, 3);
            rand_port(1'b1, 40, 3);
        join

        // MEM_LAT=1 instance: fetch latency and capture cycle
        @(posedge clk);
        #1;
        l_if_addr = 32'h0000_0104;
        l_if_req  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk1("l1_mem_en", l_mem_en, j == 1);
            chk1("l1_if_ready", l_if_ready, j == 3);
            chk1("l1_stall_if", l_stall_if, l_if_req && (j != 3));
            if (j == 1) chk("l1_mem_addr", l_mem_addr, 32'h0000_0104);
            if (j == 3) begin
                chk("l1_if_rdata", l_if_rdata, 32'h1357_9BDF);
                l_if_req = 1'b0;
            end
        end

        // reset while the access is in WAIT: no completion, then nominal service
        @(posedge clk);
        #1;
        if_q.push_back('{1'b0, seed_word(32'h0000_0300)});
        if_addr = 32'h0000_0300;
        if_req  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_if(32'h2000_0044);
        if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
